// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared CNN constants and weight-fetch state encoding
package cnn_pkg;

    localparam int WEIGHT_W = 8;
    localparam int TAPS     = 9;
    localparam int ADDR_W   = 15;
    localparam int KERNEL_W = TAPS * WEIGHT_W;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        DRAIN,
        PRESENT,
        FIN
    } fetch_state_t;

endpackage

// File: rtl/weight_packer.sv
// rtl/weight_packer.sv - tap-slot register file that assembles one packed kernel word
module weight_packer #(
    parameter int WEIGHT_W = 8,
    parameter int TAPS     = 9,
    parameter int SLOT_W   = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [SLOT_W-1:0]        wr_slot,
    input  logic [WEIGHT_W-1:0]      wr_data,
    output logic [TAPS*WEIGHT_W-1:0] kernel
);

    // Slots at or beyond TAPS (the bias byte) are simply not stored here.
    always_ff @(posedge clk) begin
        if (reset) begin
            kernel <= '0;
        end else begin
            for (int t = 0; t < TAPS; t++) begin
                if (wr_en && (wr_slot == SLOT_W'(t))) begin
                    kernel[t*WEIGHT_W +: WEIGHT_W] <= wr_data;
                end
            end
        end
    end

endmodule

// File: rtl/weight_fetch_seq.sv
// rtl/weight_fetch_seq.sv - BRAM kernel fetch sequencer; WEIGHT_FETCH_BIAS_EN adds a per-kernel bias byte
module weight_fetch_seq #(
    parameter int ADDR_W   = cnn_pkg::ADDR_W,
    parameter int WEIGHT_W = cnn_pkg::WEIGHT_W,
    parameter int TAPS     = cnn_pkg::TAPS,
    parameter int CNT_W    = 12
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        base_addr,
    input  logic [CNT_W-1:0]         num_kernels,
    output logic [ADDR_W-1:0]        bram_read_addr,
    input  logic [WEIGHT_W-1:0]      bram_data,
    output logic [TAPS*WEIGHT_W-1:0] kernel_out,
`ifdef WEIGHT_FETCH_BIAS_EN
    output logic [WEIGHT_W-1:0]      kernel_bias,
`endif
    output logic                     kernel_valid,
    input  logic                     kernel_ready,
    output logic [CNT_W-1:0]         kernel_idx,
    output logic                     busy,
    output logic                     done
);

    import cnn_pkg::*;

`ifdef WEIGHT_FETCH_BIAS_EN
    localparam int FETCH_BYTES = TAPS + 1;
`else
    localparam int FETCH_BYTES = TAPS;
`endif
    localparam int SLOT_W = $clog2(FETCH_BYTES + 1);

    fetch_state_t      state;
    logic [CNT_W-1:0]  num_q;
    logic [SLOT_W-1:0] tap_cnt;
    logic              wr_en;
    logic [SLOT_W-1:0] wr_slot;

    // bram_data always carries the byte addressed one cycle earlier.
    always_comb begin
        wr_en   = 1'b0;
        wr_slot = '0;
        if (state == ISSUE && tap_cnt != '0) begin
            wr_en   = 1'b1;
            wr_slot = tap_cnt - SLOT_W'(1);
        end else if (state == DRAIN) begin
            wr_en   = 1'b1;
            wr_slot = SLOT_W'(FETCH_BYTES - 1);
        end
    end

    weight_packer #(
        .WEIGHT_W (WEIGHT_W),
        .TAPS     (TAPS),
        .SLOT_W   (SLOT_W)
    ) u_packer (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_en),
        .wr_slot (wr_slot),
        .wr_data (bram_data),
        .kernel  (kernel_out)
    );

`ifdef WEIGHT_FETCH_BIAS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            kernel_bias <= '0;
        end else if (wr_en && (wr_slot == SLOT_W'(TAPS))) begin
            kernel_bias <= bram_data;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            bram_read_addr <= '0;
            kernel_valid   <= 1'b0;
            kernel_idx     <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            num_q          <= '0;
            tap_cnt        <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        num_q      <= num_kernels;
                        kernel_idx <= '0;
                        tap_cnt    <= '0;
                        busy       <= 1'b1;
                        if (num_kernels == '0) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            state          <= ISSUE;
                            bram_read_addr <= base_addr;
                        end
                    end
                end
                ISSUE: begin
                    bram_read_addr <= bram_read_addr + ADDR_W'(1);
                    tap_cnt        <= tap_cnt + SLOT_W'(1);
                    if (tap_cnt == SLOT_W'(FETCH_BYTES - 1)) begin
                        state <= DRAIN;
                    end
                end
                DRAIN: begin
                    kernel_valid <= 1'b1;
                    state        <= PRESENT;
                end
                PRESENT: begin
                    if (kernel_ready) begin
                        kernel_valid <= 1'b0;
                        if (kernel_idx == num_q - CNT_W'(1)) begin
                            state <= FIN;
                            done  <= 1'b1;
                        end else begin
                            // The held address was read on this edge, so it counts as tap 0
                            // of the next kernel and the first ISSUE cycle is skipped.
                            kernel_idx     <= kernel_idx + CNT_W'(1);
                            bram_read_addr <= bram_read_addr + ADDR_W'(1);
                            tap_cnt        <= SLOT_W'(1);
                            state          <= ISSUE;
                        end
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
